// File: rtl/cipher_pkg.sv
// Shared types and constants for the 3-LFSR majority keystream cipher front end.
// CIPHER_WARMUP_EN adds the WARM state to the controller encoding.
package cipher_pkg;

    localparam int KEY_BITS_C = 67;

    localparam int LFSR0_LEN = 17;
    localparam int LFSR1_LEN = 19;
    localparam int LFSR2_LEN = 31;

    localparam logic [LFSR0_LEN-1:0] LFSR0_POLY = 17'h100ab;
    localparam logic [LFSR1_LEN-1:0] LFSR1_POLY = 19'h40112;
    localparam logic [LFSR2_LEN-1:0] LFSR2_POLY = 31'h40000576;

`ifdef CIPHER_WARMUP_EN
    typedef enum logic [2:0] {IDLE, LOAD, WARM, READY, SHIFT} ctrl_state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, READY, SHIFT} ctrl_state_t;
`endif

endpackage

// File: rtl/cipher_bit_serdes.sv
// Byte <-> bit converter: LSB-first PISO toward the cipher and SIPO back from it.
module cipher_bit_serdes (
    input  logic       clk,
    input  logic       nrst,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       shift,
    input  logic       sin,
    output logic       sout,
    output logic       done,
    output logic [7:0] pout
);

    logic [7:0] byte_q;
    logic [6:0] out_sr;
    logic [2:0] bidx;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            byte_q <= '0;
            out_sr <= '0;
            bidx   <= '0;
        end else if (load) begin
            byte_q <= din;
            bidx   <= '0;
        end else if (shift) begin
            out_sr <= {sin, out_sr[6:1]};
            bidx   <= bidx + 3'd1;
        end
    end

    assign sout = byte_q[bidx];
    assign done = shift && (bidx == 3'd7);
    // bit 7 arrives on the done cycle itself, so it bypasses the register
    assign pout = {sin, out_sr};

endmodule

// File: rtl/cipher_stream_ctrl.sv
// Byte-level front end for the bit-serial 3-LFSR cipher: serial key load, then byte streaming.
// Define CIPHER_WARMUP_EN to discard WARMUP_CYCLES keystream bits after each key load.
module cipher_stream_ctrl
    import cipher_pkg::*;
#(
    parameter int KEY_BITS      = KEY_BITS_C,
    parameter int WARMUP_CYCLES = 64
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [7:0]          s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [7:0]          m_data,
    output logic                key_loaded,
    output logic                c_en,
    output logic                c_mode,
    output logic                c_in,
    input  logic                c_out
);

    localparam int CNT_W = $clog2(((KEY_BITS > WARMUP_CYCLES) ? KEY_BITS : WARMUP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(KEY_BITS - 1);
`ifdef CIPHER_WARMUP_EN
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
`endif

    ctrl_state_t         state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [KEY_BITS-1:0] key_q;
    logic                key_hs, byte_hs, seeding;
    logic                ser_bit, ser_done;
    logic [7:0]          ser_byte;

    assign key_hs  = key_valid & key_ready;
    assign byte_hs = s_valid & s_ready;
`ifdef CIPHER_WARMUP_EN
    assign seeding = (state == LOAD) || (state == WARM);
`else
    assign seeding = (state == LOAD);
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            key_q      <= '0;
            key_loaded <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
        end else begin
            state <= state_nx;
            if (key_hs) begin
                key_q      <= key;
                key_loaded <= 1'b0;
            end
            if (seeding && state_nx == READY)
                key_loaded <= 1'b1;
            // one counter serves LOAD and WARM; it restarts on every state change
            if (state_nx != state)
                cnt <= '0;
            else if (seeding)
                cnt <= cnt + 1'b1;
            if (ser_done) begin
                m_valid <= 1'b1;
                m_data  <= ser_byte;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (key_hs) state_nx = LOAD;
            LOAD: begin
`ifdef CIPHER_WARMUP_EN
                if (cnt == LOAD_LAST) state_nx = WARM;
`else
                if (cnt == LOAD_LAST) state_nx = READY;
`endif
            end
`ifdef CIPHER_WARMUP_EN
            WARM:  if (cnt == WARM_LAST) state_nx = READY;
`endif
            READY: begin
                if (key_hs)
                    state_nx = LOAD;
                else if (byte_hs)
                    state_nx = SHIFT;
            end
            SHIFT: if (ser_done) state_nx = READY;
            default: state_nx = IDLE;
        endcase
    end

    // key_ready is gated by nrst so every output reads 0 while reset is held
    always_comb begin
        key_ready = 1'b0;
        s_ready   = 1'b0;
        c_en      = 1'b0;
        c_mode    = 1'b0;
        c_in      = 1'b0;
        case (state)
            IDLE: key_ready = nrst;
            LOAD: begin
                c_en   = 1'b1;
                c_mode = 1'b1;
                c_in   = key_q[cnt];
            end
`ifdef CIPHER_WARMUP_EN
            WARM: c_en = 1'b1;
`endif
            READY: begin
                key_ready = ~m_valid;
                s_ready   = ~m_valid & ~key_valid;
            end
            SHIFT: begin
                c_en = 1'b1;
                c_in = ser_bit;
            end
            default: ;
        endcase
    end

    cipher_bit_serdes u_serdes (
        .clk   (clk),
        .nrst  (nrst),
        .load  (byte_hs),
        .din   (s_data),
        .shift (state == SHIFT),
        .sin   (c_out),
        .sout  (ser_bit),
        .done  (ser_done),
        .pout  (ser_byte)
    );

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Bench for cipher_stream_ctrl with a stand-in keystream cipher and a byte-level reference model.
module tb_cipher_stream_ctrl;

    localparam int KB = 67;
    localparam int WU = 64;
`ifdef CIPHER_WARMUP_EN
    localparam int KS_BASE = WU;
`else
    localparam int KS_BASE = 0;
`endif

    logic          clk = 1'b0, nrst = 1'b0;
    logic          key_valid = 1'b0, key_ready;
    logic [KB-1:0] key = '0;
    logic          s_valid = 1'b0, s_ready;
    logic [7:0]    s_data = '0;
    logic          m_valid, m_ready = 1'b0;
    logic [7:0]    m_data;
    logic          key_loaded, c_en, c_mode, c_in, c_out;

    int errors = 0;
    int checks = 0;

    cipher_stream_ctrl #(.KEY_BITS(KB), .WARMUP_CYCLES(WU)) dut (
        .clk(clk), .nrst(nrst),
        .key_valid(key_valid), .key_ready(key_ready), .key(key),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .key_loaded(key_loaded),
        .c_en(c_en), .c_mode(c_mode), .c_in(c_in), .c_out(c_out)
    );

    always #5 clk = ~clk;

    // keystream bit i of a seed: nonlinear, and all-zero for a zero seed
    function automatic logic ksf(input logic [KB-1:0] s, input int i);
        return s[i % KB] ^ (s[(3 * i + 5) % KB] & s[(i + 29) % KB]);
    endfunction

    function automatic logic [7:0] ks_byte(input logic [KB-1:0] k, input int idx);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = ksf(k, idx + j);
        return r;
    endfunction

    // stand-in cipher: seed chain fed LSB-first, keystream index advances per enabled cycle
    logic [KB-1:0] sd = '0;
    int            n  = 0;
    assign c_out = c_in ^ ksf(sd, n);
    always @(posedge clk) begin
        if (c_en && c_mode) begin
            sd <= {c_in, sd[KB-1:1]};
            n  <= 0;
        end else if (c_en) begin
            n <= n + 1;
        end
    end

    int en_frozen_viol = 0;
    always @(posedge clk) if (c_en && m_valid) en_frozen_viol <= en_frozen_viol + 1;

    // reference model state
    logic [KB-1:0] mkey;
    int            midx;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [KB-1:0] k);
        int w, lc, wc;
        key = k;
        key_valid = 1'b1;
        w = 0;
        while (!key_ready && w < 300) begin tick; w++; end
        check("key_ready_wait", key_ready, 1'b1);
        tick;
        key_valid = 1'b0;
        check("load_key_loaded_low", key_loaded, 1'b0);
        lc = 0;
        while (c_mode && lc < 200) begin
            if (!c_en) lc += 1000;
            lc++;
            tick;
        end
        check("load_cycles", lc, KB);
        check("load_bits", sd, k);
`ifdef CIPHER_WARMUP_EN
        wc = 0;
        while (!key_loaded && wc < 200) begin
            if (!c_en || c_mode) wc += 1000;
            wc++;
            tick;
        end
        check("warm_cycles", wc, WU);
`else
        wc = 0;
        check("warm_absent", wc, 0);
`endif
        check("key_loaded_set", key_loaded, 1'b1);
        check("ready_idle_cipher", {c_en, c_mode, c_in}, 3'b000);
        mkey = k;
        midx = KS_BASE;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, output logic [7:0] got);
        int w, lat, viol;
        logic [7:0] exp;
        s_data = b;
        s_valid = 1'b1;
        w = 0;
        while (!s_ready && w < 300) begin tick; w++; end
        check("s_ready_wait", s_ready, 1'b1);
        tick;
        s_valid = 1'b0;
        lat = 0;
        while (!m_valid && lat < 50) begin tick; lat++; end
        check("latency", lat, 8);
        exp = b ^ ks_byte(mkey, midx);
        midx += 8;
        check("m_data", m_data, exp);
        got = m_data;
        if (hold > 0) begin
            viol = 0;
            s_data = 8'($urandom);
            s_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                if (m_data !== got || m_valid !== 1'b1 || s_ready !== 1'b0 ||
                    key_ready !== 1'b0 || c_en !== 1'b0) viol++;
                tick;
            end
            s_valid = 1'b0;
            check("hold_stable", viol, 0);
        end
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        check("m_valid_clear", m_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] pt [12];
        logic [7:0] ct [12];
        logic [KB-1:0] rk;

        #12;
        check("rst_key_ready", key_ready, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m", {m_valid, m_data}, 9'h0);
        check("rst_key_loaded", key_loaded, 1'b0);
        check("rst_cipher", {c_en, c_mode, c_in}, 3'b000);
        nrst = 1'b1;
        tick;
        check("idle_key_ready", key_ready, 1'b1);
        check("idle_s_ready", s_ready, 1'b0);

        // zero key: keystream is all zero
        load_key('0);
        send_byte(8'hA5, 0, got);
        check("zero_key_pass", got, 8'hA5);

        // patterned key, a few random bytes
        load_key(67'h5_A5A5_A5A5_A5A5_A5A5);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), int'($urandom_range(0, 3)), got);

        // backpressure, then the next byte must continue the keystream
        send_byte(8'($urandom), 100, got);
        send_byte(8'($urandom), 0, got);

        // round trip: encrypt, reload same key, decrypt
        rk = {3'($urandom), 32'($urandom), 32'($urandom)};
        load_key(rk);
        for (int i = 0; i < 12; i++) begin
            pt[i] = 8'($urandom);
            send_byte(pt[i], int'($urandom_range(0, 2)), ct[i]);
        end
        load_key(rk);
        for (int i = 0; i < 12; i++) begin
            send_byte(ct[i], 0, got);
            check("roundtrip", got, pt[i]);
        end

        // collision in READY: key wins, byte waits and is taken after the load
        rk = {3'($urandom), 32'($urandom), 32'($urandom)};
        key = rk;
        key_valid = 1'b1;
        s_data = 8'h3C;
        s_valid = 1'b1;
        #1;
        check("collide_s_ready", s_ready, 1'b0);
        check("collide_key_ready", key_ready, 1'b1);
        tick;
        key_valid = 1'b0;
        check("collide_key_taken", c_mode, 1'b1);
        begin
            int w, sviol;
            w = 0;
            sviol = 0;
            while (!key_loaded && w < 300) begin
                if (s_ready) sviol++;
                tick;
                w++;
            end
            check("collide_s_blocked", sviol, 0);
        end
        check("collide_seed", sd, rk);
        mkey = rk;
        midx = KS_BASE;
        send_byte(8'h3C, 0, got);

        // reset at SHIFT bit 3
        s_data = 8'($urandom);
        s_valid = 1'b1;
        begin
            int w;
            w = 0;
            while (!s_ready && w < 300) begin tick; w++; end
        end
        tick;
        s_valid = 1'b0;
        tick; tick; tick;
        check("shift_active", c_en, 1'b1);
        #2 nrst = 1'b0;
        #1;
        check("mid_rst_ready", {key_ready, s_ready}, 2'b00);
        check("mid_rst_m", {m_valid, m_data}, 9'h0);
        check("mid_rst_key_loaded", key_loaded, 1'b0);
        check("mid_rst_cipher", {c_en, c_mode, c_in}, 3'b000);
        #2 nrst = 1'b1;
        tick;
        check("post_rst_key_ready", key_ready, 1'b1);
        check("post_rst_m_valid", m_valid, 1'b0);

        check("en_frozen", en_frozen_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
